// File: rtl/sys_bus_pkg.sv
// Shared types and constants for the system-bus initiator.
package sys_bus_pkg;

   localparam int SYS_AW = 32;
   localparam int SYS_DW = 32;

   // Byte select driven while a strobe is active (full-word accesses only)
   localparam logic [3:0] SYS_SEL_ALL = 4'hF;

   // Bit positions inside the internal response code register
   localparam int RSP_ERR_BIT = 0;
   localparam int RSP_TO_BIT  = 1;
   localparam int RSP_CODE_W  = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_RESP
   } state_t;

   // Saturating increment for 8-bit event counters
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/sys_bus_initiator.sv
// Single-outstanding system-bus initiator: command in, one strobe on the bus,
// wait for ack (with optional timeout), then one response out.
module sys_bus_initiator
   import sys_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned TW      = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_write_i,
   input  logic [SYS_AW-1:0] cmd_addr_i,
   input  logic [SYS_DW-1:0] cmd_wdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [SYS_DW-1:0] rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              rsp_timeout_o,
   output logic [SYS_AW-1:0] sys_addr,
   output logic [SYS_DW-1:0] sys_wdata,
   output logic [3:0]        sys_sel,
   output logic              sys_wen,
   output logic              sys_ren,
   input  logic [SYS_DW-1:0] sys_rdata,
   input  logic              sys_err,
   input  logic              sys_ack,
   output logic              busy_o,
   output logic [15:0]       txn_cnt_o,
   output logic [7:0]        timeout_cnt_o
);

   // Last WAIT count before the timeout fires (unused when TIMEOUT is 0)
   localparam int unsigned    TO_LAST_INT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
   localparam logic [TW-1:0]  TO_LAST     = TW'(TO_LAST_INT);

   state_t                  state_q, state_d;
   logic                    write_q, write_d;
   logic [SYS_AW-1:0]       addr_q, addr_d;
   logic [SYS_DW-1:0]       wdata_q, wdata_d;
   logic                    wen_q, wen_d;
   logic                    ren_q, ren_d;
   logic [3:0]              sel_q, sel_d;
   logic [TW-1:0]           cnt_q, cnt_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [SYS_DW-1:0]       rdata_q, rdata_d;
   logic [RSP_CODE_W-1:0]   code_q, code_d;
   logic [15:0]             txn_q, txn_d;
   logic [7:0]              tocnt_q, tocnt_d;
   logic                    busy_q, busy_d;

   // Ready is decoded from the state; held low while reset is asserted
   assign cmd_ready_o = (state_q == ST_IDLE) && !rst_i;

   // Next-state and next-output decode
   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wen_d       = 1'b0;
      ren_d       = 1'b0;
      sel_d       = '0;
      cnt_d       = cnt_q;
      rsp_valid_d = rsp_valid_q;
      rdata_d     = rdata_q;
      code_d      = code_q;
      txn_d       = txn_q;
      tocnt_d     = tocnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i && cmd_ready_o) begin
               write_d = cmd_write_i;
               addr_d  = cmd_addr_i;
               wdata_d = cmd_wdata_i;
               // Strobe registers load here so the pulse lands in REQ
               wen_d   = cmd_write_i;
               ren_d   = !cmd_write_i;
               sel_d   = SYS_SEL_ALL;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            // Any ack seen now cannot belong to this strobe; it is ignored
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (sys_ack) begin
               code_d              = '0;
               code_d[RSP_ERR_BIT] = sys_err;
               rdata_d             = write_q ? '0 : sys_rdata;
               rsp_valid_d         = 1'b1;
               state_d             = ST_RESP;
            end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
               code_d              = '0;
               code_d[RSP_ERR_BIT] = 1'b1;
               code_d[RSP_TO_BIT]  = 1'b1;
               rdata_d             = '0;
               tocnt_d             = sat_inc8(tocnt_q);
               rsp_valid_d         = 1'b1;
               state_d             = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               txn_d       = txn_q + 16'd1;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs; reset aborts any transaction in flight
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wen_q       <= 1'b0;
         ren_q       <= 1'b0;
         sel_q       <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         code_q      <= '0;
         txn_q       <= '0;
         tocnt_q     <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wen_q       <= wen_d;
         ren_q       <= ren_d;
         sel_q       <= sel_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         code_q      <= code_d;
         txn_q       <= txn_d;
         tocnt_q     <= tocnt_d;
         busy_q      <= busy_d;
      end
   end

   assign sys_addr      = addr_q;
   assign sys_wdata     = wdata_q;
   assign sys_sel       = sel_q;
   assign sys_wen       = wen_q;
   assign sys_ren       = ren_q;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_rdata_o   = rdata_q;
   assign rsp_err_o     = code_q[RSP_ERR_BIT];
   assign rsp_timeout_o = code_q[RSP_TO_BIT];
   assign busy_o        = busy_q;
   assign txn_cnt_o     = txn_q;
   assign timeout_cnt_o = tocnt_q;

endmodule

// File: tb/tb_sys_bus_initiator.sv
// Bench for sys_bus_initiator: programmable responder, timeline model,
// per-cycle compare and directed scenarios with literal expectations.
module tb_sys_bus_initiator;

   localparam int TO = 16;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic        cmd_write_i;
   logic [31:0] cmd_addr_i;
   logic [31:0] cmd_wdata_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        rsp_timeout_o;
   logic [31:0] sys_addr;
   logic [31:0] sys_wdata;
   logic [3:0]  sys_sel;
   logic        sys_wen;
   logic        sys_ren;
   logic [31:0] sys_rdata = 32'h0;
   logic        sys_err   = 1'b0;
   logic        sys_ack   = 1'b0;
   logic        busy_o;
   logic [15:0] txn_cnt_o;
   logic [7:0]  timeout_cnt_o;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   sys_bus_initiator #(.TIMEOUT(TO), .TW(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
      .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_sel(sys_sel),
      .sys_wen(sys_wen), .sys_ren(sys_ren),
      .sys_rdata(sys_rdata), .sys_err(sys_err), .sys_ack(sys_ack),
      .busy_o(busy_o), .txn_cnt_o(txn_cnt_o), .timeout_cnt_o(timeout_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Cycle index; reads at posedge see the cycle that is ending
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
      end
   endtask

   // ---------------- responder (registered, programmable) ----------------
   int          rsp_delay    = 1;     // ack appears this many cycles after the strobe cycle
   bit          rsp_never    = 1'b0;
   bit          rsp_err_inj  = 1'b0;
   logic [31:0] rsp_data     = 32'h0;
   int          late_ack_cyc = -1;    // extra stray ack (err, junk data) in this cycle
   int          r_strobe     = 0;
   bit          r_armed      = 1'b0;

   wire strobe_now = sys_wen || sys_ren;
   int  s_eff;
   bit  a_eff;
   assign s_eff = strobe_now ? cyc : r_strobe;
   assign a_eff = strobe_now ? !rsp_never : r_armed;

   // Responder ack generation
   always @(posedge clk_i) begin
      sys_ack   <= 1'b0;
      sys_err   <= 1'b0;
      sys_rdata <= 32'h0;
      r_strobe  <= s_eff;
      r_armed   <= a_eff;
      if (a_eff && (cyc + 1 == s_eff + rsp_delay)) begin
         sys_ack   <= 1'b1;
         sys_err   <= rsp_err_inj;
         sys_rdata <= rsp_data;
         r_armed   <= 1'b0;
      end else if (cyc + 1 == late_ack_cyc) begin
         sys_ack   <= 1'b1;
         sys_err   <= 1'b1;
         sys_rdata <= 32'hDEADBEEF;
      end
   end

   // ---------------- timeline model ----------------
   // A transaction accepted in cycle t strobes in t+1 and responds in
   // t+2+min(delay,TO); beyond TO it is a timeout response.
   bit          m_ok = 1'b0;
   bit          m_act = 1'b0;
   int          m_tacc = 0;
   int          m_trsp = 0;
   bit          m_w = 1'b0;
   logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
   bit          m_err = 1'b0, m_to = 1'b0;
   logic [15:0] m_txn = 0;
   logic [7:0]  m_tocnt = 0;

   always @(posedge clk_i) begin
      if (rst_i) begin
         m_ok    <= 1'b1;
         m_act   <= 1'b0;
         m_txn   <= 16'h0;
         m_tocnt <= 8'h0;
         m_addr  <= 32'h0;
         m_wdata <= 32'h0;
      end else if (m_ok) begin
         if (!m_act && cmd_valid_i) begin
            m_act   <= 1'b1;
            m_tacc  <= cyc;
            m_w     <= cmd_write_i;
            m_addr  <= cmd_addr_i;
            m_wdata <= cmd_wdata_i;
            if (!rsp_never && rsp_delay <= TO) begin
               m_trsp  <= cyc + 2 + rsp_delay;
               m_to    <= 1'b0;
               m_err   <= rsp_err_inj;
               m_rdata <= cmd_write_i ? 32'h0 : rsp_data;
            end else begin
               m_trsp  <= cyc + 2 + TO;
               m_to    <= 1'b1;
               m_err   <= 1'b1;
               m_rdata <= 32'h0;
            end
         end else if (m_act && cyc >= m_trsp && rsp_ready_i) begin
            m_act <= 1'b0;
            m_txn <= m_txn + 16'd1;
            if (m_to && m_tocnt != 8'hFF) m_tocnt <= m_tocnt + 8'd1;
         end
      end
   end

   wire       e_strobe = m_act && (cyc == m_tacc + 1);
   wire       e_rsp    = m_act && (cyc >= m_trsp);
   wire [7:0] e_tocnt  = (e_rsp && m_to && m_tocnt != 8'hFF) ? m_tocnt + 8'd1 : m_tocnt;

   // Per-cycle compare against the model
   always @(negedge clk_i) begin
      if (m_ok) begin
         chk("cmd_ready", 32'(cmd_ready_o), 32'(!rst_i && !m_act));
         chk("busy",      32'(busy_o),      32'(m_act && cyc >= m_tacc + 1));
         chk("sys_wen",   32'(sys_wen),     32'(e_strobe && m_w));
         chk("sys_ren",   32'(sys_ren),     32'(e_strobe && !m_w));
         chk("sys_sel",   32'(sys_sel),     e_strobe ? 32'hF : 32'h0);
         chk("sys_addr",  sys_addr,         m_addr);
         chk("sys_wdata", sys_wdata,        m_wdata);
         chk("rsp_valid", 32'(rsp_valid_o), 32'(e_rsp));
         if (e_rsp) begin
            chk("rsp_rdata",   rsp_rdata_o,         m_rdata);
            chk("rsp_err",     32'(rsp_err_o),      32'(m_err));
            chk("rsp_timeout", 32'(rsp_timeout_o),  32'(m_to));
         end
         chk("txn_cnt",     32'(txn_cnt_o),     32'(m_txn));
         chk("timeout_cnt", 32'(timeout_cnt_o), 32'(e_tocnt));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_resp(input int d, input bit never, input bit err, input logic [31:0] data);
      rsp_delay   = d;
      rsp_never   = never;
      rsp_err_inj = err;
      rsp_data    = data;
   endtask

   // Present a command until accepted; returns the accept cycle, ends in the strobe cycle
   task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d, output int acc);
      int n = 0;
      cmd_valid_i = 1'b1;
      cmd_write_i = w;
      cmd_addr_i  = a;
      cmd_wdata_i = d;
      while (!cmd_ready_o && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) chk("accept_timeout", 32'(cmd_ready_o), 32'h1);
      acc = cyc;
      tick();
      cmd_valid_i = 1'b0;
   endtask

   task automatic wait_rsp(output int vc);
      int n = 0;
      while (!rsp_valid_o && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) chk("rsp_wait_timeout", 32'(rsp_valid_o), 32'h1);
      vc = cyc;
   endtask

   initial begin
      int acc, vc, x;
      rst_i       = 1'b1;
      cmd_valid_i = 1'b0;
      cmd_write_i = 1'b0;
      cmd_addr_i  = 32'h0;
      cmd_wdata_i = 32'h0;
      rsp_ready_i = 1'b1;
      repeat (3) tick();
      chk("rst_ready",   32'(cmd_ready_o), 32'h0);
      chk("rst_valid",   32'(rsp_valid_o), 32'h0);
      chk("rst_txn",     32'(txn_cnt_o),   32'h0);
      chk("rst_busy",    32'(busy_o),      32'h0);
      rst_i = 1'b0;
      #1 chk("ready_after_rst", 32'(cmd_ready_o), 32'h1);
      tick();

      // 1: write 0x30 / 0xA5, ack next cycle
      set_resp(1, 1'b0, 1'b0, 32'h12345678);
      issue(1'b1, 32'h30, 32'hA5, acc);
      $display("txn write addr=0x30 accepted cyc=%0d", acc);
      chk("t1_wen",  32'(sys_wen), 32'h1);
      chk("t1_addr", sys_addr,     32'h30);
      chk("t1_sel",  32'(sys_sel), 32'hF);
      tick();
      chk("t1_wen_pulse", 32'(sys_wen), 32'h0);
      wait_rsp(vc);
      chk("t1_latency", 32'(vc - acc), 32'd3);
      chk("t1_rdata",   rsp_rdata_o,   32'h0);
      chk("t1_err",     32'(rsp_err_o), 32'h0);
      tick();
      chk("t1_txn", 32'(txn_cnt_o), 32'd1);

      // 2: read 0x00 returns 1
      set_resp(1, 1'b0, 1'b0, 32'h00000001);
      issue(1'b0, 32'h0, 32'h0, acc);
      $display("txn read addr=0x00 accepted cyc=%0d", acc);
      chk("t2_ren", 32'(sys_ren), 32'h1);
      wait_rsp(vc);
      chk("t2_rdata", rsp_rdata_o,    32'h1);
      chk("t2_err",   32'(rsp_err_o), 32'h0);
      tick();

      // 3: no ack -> timeout, then a stray late ack while held in RESP
      set_resp(1, 1'b1, 1'b0, 32'h0);
      rsp_ready_i = 1'b0;
      issue(1'b0, 32'h50, 32'h0, acc);
      wait_rsp(vc);
      $display("txn read addr=0x50 timeout rsp cyc=%0d", vc);
      chk("t3_latency", 32'(vc - acc), 32'd18);
      chk("t3_timeout", 32'(rsp_timeout_o), 32'h1);
      chk("t3_err",     32'(rsp_err_o),     32'h1);
      chk("t3_tocnt",   32'(timeout_cnt_o), 32'd1);
      late_ack_cyc = vc + 5;
      repeat (8) tick();
      chk("t3_late_rdata",   rsp_rdata_o,         32'h0);
      chk("t3_late_timeout", 32'(rsp_timeout_o),  32'h1);
      rsp_ready_i = 1'b1;
      tick();
      chk("t3_txn", 32'(txn_cnt_o), 32'd3);

      // 4a: responder error with ack
      set_resp(2, 1'b0, 1'b1, 32'hCAFE0000);
      issue(1'b1, 32'h60, 32'h77, acc);
      wait_rsp(vc);
      $display("txn write addr=0x60 err rsp cyc=%0d", vc);
      chk("t4a_err",     32'(rsp_err_o),     32'h1);
      chk("t4a_timeout", 32'(rsp_timeout_o), 32'h0);
      tick();

      // 4b: ack in the timeout expiry cycle wins
      set_resp(TO, 1'b0, 1'b0, 32'hBEEF0016);
      issue(1'b0, 32'h64, 32'h0, acc);
      wait_rsp(vc);
      $display("txn read addr=0x64 ack at expiry rsp cyc=%0d", vc);
      chk("t4b_latency", 32'(vc - acc), 32'd18);
      chk("t4b_timeout", 32'(rsp_timeout_o), 32'h0);
      chk("t4b_rdata",   rsp_rdata_o,        32'hBEEF0016);
      chk("t4b_tocnt",   32'(timeout_cnt_o), 32'd1);
      tick();

      // 5: response back-pressure with a command waiting
      set_resp(1, 1'b0, 1'b0, 32'h0000AAAA);
      rsp_ready_i = 1'b0;
      issue(1'b1, 32'h40, 32'h11, acc);
      wait_rsp(vc);
      cmd_valid_i = 1'b1;
      cmd_write_i = 1'b0;
      cmd_addr_i  = 32'h44;
      repeat (10) tick();
      chk("t5_ready_held", 32'(cmd_ready_o), 32'h0);
      rsp_ready_i = 1'b1;
      x = cyc;
      tick();
      chk("t5_ready_after", 32'(cmd_ready_o), 32'h1);
      chk("t5_accept_cyc",  32'(cyc - x),     32'd1);
      tick();
      chk("t5_ren", 32'(sys_ren), 32'h1);
      cmd_valid_i = 1'b0;
      wait_rsp(vc);
      $display("txn read addr=0x44 after backpressure rsp cyc=%0d", vc);
      chk("t5_rdata", rsp_rdata_o, 32'h0000AAAA);
      tick();
      chk("t5_txn", 32'(txn_cnt_o), 32'd7);

      // 6: reset during WAIT, late ack afterwards ignored
      set_resp(6, 1'b0, 1'b0, 32'h55555555);
      issue(1'b0, 32'h70, 32'h0, acc);
      tick();
      rst_i = 1'b1;
      tick();
      $display("txn read addr=0x70 aborted by reset cyc=%0d", cyc);
      chk("t6_valid", 32'(rsp_valid_o),   32'h0);
      chk("t6_busy",  32'(busy_o),        32'h0);
      chk("t6_txn",   32'(txn_cnt_o),     32'h0);
      chk("t6_tocnt", 32'(timeout_cnt_o), 32'h0);
      chk("t6_addr",  sys_addr,           32'h0);
      chk("t6_ren",   32'(sys_ren),       32'h0);
      rst_i = 1'b0;
      repeat (8) tick();
      chk("t6_no_rsp", 32'(rsp_valid_o), 32'h0);
      set_resp(1, 1'b0, 1'b0, 32'h0);
      issue(1'b1, 32'h80, 32'h99, acc);
      wait_rsp(vc);
      $display("txn write addr=0x80 after reset rsp cyc=%0d", vc);
      chk("t6_post_latency", 32'(vc - acc), 32'd3);
      tick();
      chk("t6_post_txn", 32'(txn_cnt_o), 32'd1);

      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sys_bus_initiator.md
Name: sys_bus_initiator

Overview:
- Master-side counterpart of the housekeeping-style system-bus responders; issues single read/write transactions onto the 32-bit sys bus (addr/wdata/sel/wen/ren -> rdata/err/ack).
- Accepts commands on a valid/ready interface and returns one response per command, with ack timeout protection.
- Used by on-chip sequencers and self-test logic to program or read back responder registers without the PS.

Parameters:
- TIMEOUT, 255, ack-wait limit in clk_i cycles after the strobe; 0 = wait forever.
- TW, 8, width of the timeout counter; must satisfy TIMEOUT < 2**TW.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  32  target address
- cmd_wdata_i  in  32  write data; ignored for reads
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  32  read data; 0 for writes and timeouts
- rsp_err_o  out  1  responder err or timeout
- rsp_timeout_o  out  1  no ack within TIMEOUT
- sys_addr  out  32  bus address
- sys_wdata  out  32  bus write data
- sys_sel  out  4  byte select; constant 4'hF while a strobe is active, else 0
- sys_wen  out  1  write strobe, one cycle
- sys_ren  out  1  read strobe, one cycle
- sys_rdata  in  32  bus read data
- sys_err  in  1  bus error
- sys_ack  in  1  bus acknowledge
- busy_o  out  1  high in any state except IDLE
- txn_cnt_o  out  16  completed responses (acked or timed out), wraps at 0xFFFF -> 0
- timeout_cnt_o  out  8  timeout events, saturates at 0xFF

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. cmd_ready_o goes high the first cycle after rst_i deasserts.
- Reset mid-transaction: abort immediately, no response emitted, counters cleared. A late ack after reset is ignored.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i & cmd_ready_o: latch write, addr and wdata; go to REQ.
- REQ (exactly 1 cycle):
  - Assert sys_wen or sys_ren and sys_sel = 4'hF.
  - sys_addr and sys_wdata come from the latch. Both stay stable from REQ until leaving WAIT, and hold their last value otherwise.
  - Clear the timeout counter; go to WAIT.
  - sys_ack seen in REQ is ignored, because responders register ack.
- WAIT:
  - If sys_ack: capture sys_err into rsp_err_o, set rsp_timeout_o = 0, capture sys_rdata for reads (0 for writes); go to RESP.
  - Else, if TIMEOUT != 0 and counter == TIMEOUT-1: set rsp_err_o = 1, rsp_timeout_o = 1, rsp_rdata_o = 0, increment timeout_cnt_o (saturating); go to RESP.
  - Else increment the counter.
  - Ack arriving in the same cycle as timeout expiry: the ack wins.
- RESP:
  - rsp_valid_o = 1; all rsp_* fields held stable until rsp_ready_i.
  - On rsp_ready_i: increment txn_cnt_o, drop rsp_valid_o, go to IDLE.
  - cmd_ready_o is low throughout RESP.
  - sys_ack arriving in RESP or IDLE (late ack after a timeout) is ignored and does not alter the held response.
- Latency: accept cycle 0, strobe cycle 1, ack cycle 2 with a registered responder, rsp_valid_o cycle 3.
- Throughput: with rsp_ready_i held high, the next command can be accepted at cycle 4, i.e. one transaction per 4 cycles.
- Only one transaction is ever outstanding; no pipelining of strobes.
- All outputs are registered except cmd_ready_o, which is decoded from the state register.

Decomposition:
- Shared package sys_bus_pkg:
  - State enum (IDLE/REQ/WAIT/RESP).
  - SYS_SEL_ALL = 4'hF.
  - Address and data width constants (32).
  - Response-code bit positions.
- Single module with no sub-module required. The timeout counter stays inline.
- A reusable sys_bus_resp_model (bench-only) provides a responder with programmable ack delay and err injection.

Test Plan:
- Write, cmd addr 0x30, wdata 0xA5, responder acks next cycle -> sys_wen high for exactly cycle 1 with sys_addr 0x30 and sys_sel 4'hF; rsp_valid_o at cycle 3 with err 0, timeout 0, rdata 0; txn_cnt_o = 1.
- Read addr 0x00, responder returns 0x00000001 -> sys_ren one-cycle pulse; rsp_rdata_o = 0x00000001, rsp_err_o = 0.
- TIMEOUT=16, responder never acks -> rsp_timeout_o = 1 and rsp_err_o = 1, 16 cycles after the strobe; timeout_cnt_o = 1. A late ack 5 cycles later leaves the response unchanged.
- Responder asserts err with ack -> rsp_err_o = 1, rsp_timeout_o = 0. Separately, ack coinciding with the timeout expiry cycle -> rsp_timeout_o = 0.
- rsp_ready_i held low for 10 cycles with cmd_valid_i held high -> response fields stable, cmd_ready_o = 0, no further sys_wen/sys_ren pulses. After release, the next command is accepted one cycle later.
- rst_i asserted during WAIT -> next cycle all outputs 0, no rsp_valid_o, txn_cnt_o = 0. The first command after reset completes normally.
